// File: rtl/mem_responder_if.sv
// Purpose : request/response bundle between a memory controller (master) and
//           the memory responder (slave), one read and one write channel per lane.
// Ports   : per-lane read valid/address -> ready/data, write valid/address/data
//           -> ready, plus a per-lane busy indication from the responder.
interface mem_responder_if #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 16,
  parameter int NUM_CHANNELS = 1
);
  logic [NUM_CHANNELS-1:0]           mem_read_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address;
  logic [NUM_CHANNELS-1:0]           mem_read_ready;
  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data;
  logic [NUM_CHANNELS-1:0]           mem_write_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address;
  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data;
  logic [NUM_CHANNELS-1:0]           mem_write_ready;
  logic [NUM_CHANNELS-1:0]           ch_busy;

  // Controller side: issues requests, observes completions.
  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready,
    input  ch_busy
  );

  // Memory side: accepts requests, produces completions.
  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready,
    output ch_busy
  );
endinterface

// File: rtl/mem_responder.sv
// Purpose : cycle-accurate external memory model; each lane serves one read or
//           write request at a time against a shared 2^ADDR_BITS x DATA_BITS array.
// Latency : ready pulses READ_LATENCY / WRITE_LATENCY edges after the accepting edge.
// Backpr. : a lane accepts nothing new until its completed request's valid drops.
// Ports   : clk, reset (async, active-high); bus (slave modport of
//           mem_responder_if) carries the per-lane request/response signals and
//           ch_busy; load_en/load_addr/load_data form a backdoor array write port.
module mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CHANNELS  = 1,
  parameter int READ_LATENCY  = 2,   // >= 1
  parameter int WRITE_LATENCY = 2,   // >= 1
  parameter int WRITE_ENABLE  = 1    // 0: writes are acknowledged but dropped
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_responder_if.slave       bus,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [DATA_BITS-1:0] load_data
);

  localparam int DEPTH    = 1 << ADDR_BITS;
  localparam int MAX_LAT  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_BITS = $clog2(MAX_LAT + 1);

  // Counter preload values: the counter reaches zero on the edge before the
  // one that produces ready, so LATENCY-1 gives exactly LATENCY edges.
  localparam logic [CNT_BITS-1:0] RD_CNT_INIT = CNT_BITS'(READ_LATENCY - 1);
  localparam logic [CNT_BITS-1:0] WR_CNT_INIT = CNT_BITS'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef enum logic {
    KIND_READ  = 1'b0,
    KIND_WRITE = 1'b1
  } kind_t;

  // Storage array: deliberately not reset so contents survive reset.
  logic [DATA_BITS-1:0] mem [DEPTH];

  // Per-lane request context.
  state_t               state [NUM_CHANNELS];
  kind_t                kind  [NUM_CHANNELS];
  logic [CNT_BITS-1:0]  cnt   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wdata [NUM_CHANNELS];

  // Registered lane outputs.
  logic [NUM_CHANNELS-1:0]           read_ready;
  logic [NUM_CHANNELS-1:0]           write_ready;
  logic [NUM_CHANNELS*DATA_BITS-1:0] read_data;

  // Unpacked views of the flattened request buses.
  logic [ADDR_BITS-1:0] rd_addr_in [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] wr_addr_in [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wr_data_in [NUM_CHANNELS];

  // Lane is completing a write on this edge and the array is writable.
  logic [NUM_CHANNELS-1:0] commit;
  logic [NUM_CHANNELS-1:0] busy;

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      rd_addr_in[i] = bus.mem_read_address[i*ADDR_BITS +: ADDR_BITS];
      wr_addr_in[i] = bus.mem_write_address[i*ADDR_BITS +: ADDR_BITS];
      wr_data_in[i] = bus.mem_write_data[i*DATA_BITS +: DATA_BITS];
      commit[i]     = (WRITE_ENABLE != 0) && (state[i] == BUSY) &&
                      (cnt[i] == '0) && (kind[i] == KIND_WRITE);
      busy[i]       = (state[i] != IDLE);
    end
  end

  // Lane FSMs. All lanes share one clocked block; each iteration only touches
  // its own lane's context and output bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state[i] <= IDLE;
        kind[i]  <= KIND_READ;
        cnt[i]   <= '0;
        addr[i]  <= '0;
        wdata[i] <= '0;
      end
      read_ready  <= '0;
      write_ready <= '0;
      read_data   <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        case (state[i])
          IDLE: begin
            // Read wins a tie; the write simply stays pending on the bus.
            if (bus.mem_read_valid[i]) begin
              state[i] <= BUSY;
              kind[i]  <= KIND_READ;
              cnt[i]   <= RD_CNT_INIT;
              addr[i]  <= rd_addr_in[i];
            end else if (bus.mem_write_valid[i]) begin
              state[i] <= BUSY;
              kind[i]  <= KIND_WRITE;
              cnt[i]   <= WR_CNT_INIT;
              addr[i]  <= wr_addr_in[i];
              wdata[i] <= wr_data_in[i];
            end
          end

          BUSY: begin
            if (cnt[i] == '0) begin
              state[i] <= RESPOND;
              if (kind[i] == KIND_READ) begin
                read_ready[i] <= 1'b1;
                // Nonblocking read of the array: a write landing on the same
                // edge is not visible here, so the pre-edge value is returned.
                read_data[i*DATA_BITS +: DATA_BITS] <= mem[addr[i]];
              end else begin
                write_ready[i] <= 1'b1;
              end
            end else begin
              cnt[i] <= cnt[i] - CNT_BITS'(1);
            end
          end

          RESPOND: begin
            read_ready[i]  <= 1'b0;
            write_ready[i] <= 1'b0;
            state[i]       <= RELEASE;
          end

          RELEASE: begin
            // Hold off until the completed request's valid is seen low so a
            // valid that lingers past ready is not taken as a new request.
            if (kind[i] == KIND_READ) begin
              if (!bus.mem_read_valid[i]) state[i] <= IDLE;
            end else begin
              if (!bus.mem_write_valid[i]) state[i] <= IDLE;
            end
          end

          default: state[i] <= IDLE;
        endcase
      end
    end
  end

  // Array update. Later assignments override earlier ones on the same edge:
  // backdoor load first, then lanes in ascending index order, so the highest
  // lane wins an address collision. Nothing is written while reset is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (load_en) begin
        mem[load_addr] <= load_data;
      end
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (commit[i]) begin
          mem[addr[i]] <= wdata[i];
        end
      end
    end
  end

  assign bus.mem_read_ready  = read_ready;
  assign bus.mem_write_ready = write_ready;
  assign bus.mem_read_data   = read_data;
  assign bus.ch_busy         = busy;

endmodule

// File: tb/tb_mem_responder.sv
// Purpose : self-checking bench for mem_responder; a lane-level behavioural
//           model predicts every output each cycle, directed scenarios pin
//           the model with literal expectations, then randomized traffic runs.
module tb_mem_responder;

  localparam int AB    = 8;
  localparam int DB    = 16;
  localparam int NC    = 2;
  localparam int RL    = 2;
  localparam int WL    = 3;
  localparam int DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_en = 1'b0;
  logic [AB-1:0] load_addr = '0;
  logic [DB-1:0] load_data = '0;
  logic          load2_en = 1'b0;
  logic [AB-1:0] load2_addr = '0;
  logic [DB-1:0] load2_data = '0;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC)) bus ();
  mem_responder_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(1))  bus2 ();

  // Main device: two lanes, writable, unequal latencies.
  mem_responder #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL), .WRITE_ENABLE(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  // Program-memory style device: writes acknowledged but dropped.
  mem_responder #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(1),
    .READ_LATENCY(2), .WRITE_LATENCY(2), .WRITE_ENABLE(0)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(bus2),
    .load_en(load2_en), .load_addr(load2_addr), .load_data(load2_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model of the main device ----------------
  // Each lane is described by "is a request outstanding, which edge accepted
  // it, what kind". Completion happens at accept+latency; the lane becomes
  // free at the first edge from accept+latency+2 on where the valid is low.
  logic [DB-1:0] m_mem   [DEPTH];
  bit            m_busy  [NC];
  int            m_acc   [NC];
  bit            m_write [NC];
  logic [AB-1:0] m_addr  [NC];
  logic [DB-1:0] m_wdata [NC];
  bit            m_commit[NC];
  logic [NC-1:0] e_rrdy = '0;
  logic [NC-1:0] e_wrdy = '0;
  logic [DB-1:0] e_rdata [NC];
  int            edge_n = 0;

  always @(posedge clk or posedge reset) begin
    int lat;
    bit vld;
    if (reset) begin
      for (int c = 0; c < NC; c++) begin
        m_busy[c]  = 1'b0;
        e_rdata[c] = '0;
      end
      e_rrdy = '0;
      e_wrdy = '0;
    end else begin
      edge_n++;
      e_rrdy = '0;
      e_wrdy = '0;
      for (int c = 0; c < NC; c++) begin
        m_commit[c] = 1'b0;
        if (!m_busy[c]) begin
          if (bus.mem_read_valid[c]) begin
            m_busy[c] = 1'b1; m_write[c] = 1'b0; m_acc[c] = edge_n;
            m_addr[c] = bus.mem_read_address[c*AB +: AB];
          end else if (bus.mem_write_valid[c]) begin
            m_busy[c] = 1'b1; m_write[c] = 1'b1; m_acc[c] = edge_n;
            m_addr[c]  = bus.mem_write_address[c*AB +: AB];
            m_wdata[c] = bus.mem_write_data[c*DB +: DB];
          end
        end else begin
          lat = m_write[c] ? WL : RL;
          vld = m_write[c] ? bus.mem_write_valid[c] : bus.mem_read_valid[c];
          if (edge_n == m_acc[c] + lat) begin
            if (m_write[c]) begin
              e_wrdy[c] = 1'b1; m_commit[c] = 1'b1;
            end else begin
              e_rrdy[c] = 1'b1; e_rdata[c] = m_mem[m_addr[c]];
            end
          end else if (edge_n >= m_acc[c] + lat + 2 && !vld) begin
            m_busy[c] = 1'b0;
          end
        end
      end
      // Reads above saw the pre-edge array; now apply this edge's writes.
      if (load_en) m_mem[load_addr] = load_data;
      for (int c = 0; c < NC; c++)
        if (m_commit[c]) m_mem[m_addr[c]] = m_wdata[c];
    end
  end

  // Compare process: every cycle, every lane, every output.
  always @(negedge clk) begin
    for (int c = 0; c < NC; c++) begin
      check($sformatf("read_ready ch%0d", c),  32'(bus.mem_read_ready[c]),  32'(e_rrdy[c]));
      check($sformatf("write_ready ch%0d", c), 32'(bus.mem_write_ready[c]), 32'(e_wrdy[c]));
      check($sformatf("read_data ch%0d", c),   32'(bus.mem_read_data[c*DB +: DB]), 32'(e_rdata[c]));
      check($sformatf("ch_busy ch%0d", c),     32'(bus.ch_busy[c]),         32'(m_busy[c]));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [AB-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AB'($urandom);
    return AB'($urandom_range(0, 7));
  endfunction

  task automatic drive_req(input bit d2, input int ch, input bit wr, input logic v,
                           input logic [AB-1:0] a, input logic [DB-1:0] d);
    if (d2) begin
      if (wr) begin
        bus2.mem_write_valid[0] = v; bus2.mem_write_address = a; bus2.mem_write_data = d;
      end else begin
        bus2.mem_read_valid[0] = v; bus2.mem_read_address = a;
      end
    end else begin
      if (wr) begin
        bus.mem_write_valid[ch] = v;
        bus.mem_write_address[ch*AB +: AB] = a;
        bus.mem_write_data[ch*DB +: DB] = d;
      end else begin
        bus.mem_read_valid[ch] = v;
        bus.mem_read_address[ch*AB +: AB] = a;
      end
    end
  endtask

  function automatic logic get_rdy(input bit d2, input int ch, input bit wr);
    if (d2) return wr ? bus2.mem_write_ready[0] : bus2.mem_read_ready[0];
    return wr ? bus.mem_write_ready[ch] : bus.mem_read_ready[ch];
  endfunction

  // Called just after a rising edge. Holds valid until ready is seen, keeps
  // it one more edge (lingering), then drops it. lat counts edges from the
  // accepting edge to the edge that raised ready; again is ready one cycle on.
  task automatic do_op(input bit d2, input int ch, input bit wr, input logic [AB-1:0] a,
                       input logic [DB-1:0] d, output int lat, output logic [DB-1:0] rd,
                       output logic again);
    lat = -99; rd = '0; again = 1'b0;
    drive_req(d2, ch, wr, 1'b1, a, d);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (get_rdy(d2, ch, wr)) begin
        lat = k - 2;
        rd  = d2 ? bus2.mem_read_data : bus.mem_read_data[ch*DB +: DB];
        break;
      end
    end
    @(posedge clk); #1;
    drive_req(d2, ch, wr, 1'b0, a, d);
    @(negedge clk);
    again = get_rdy(d2, ch, wr);
    @(posedge clk); #1;
  endtask

  task automatic do_load(input bit d2, input logic [AB-1:0] a, input logic [DB-1:0] d);
    if (d2) begin load2_en = 1'b1; load2_addr = a; load2_data = d; end
    else    begin load_en  = 1'b1; load_addr  = a; load_data  = d; end
    @(posedge clk); #1;
    load_en = 1'b0; load2_en = 1'b0;
  endtask

  task automatic rand_chan(input int ch, input int n);
    logic rv, wv;
    rv = 1'b0; wv = 1'b0;
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) rv = ~rv;
      if ($urandom_range(0, 3) == 0) wv = ~wv;
      bus.mem_read_valid[ch]  = rv;
      bus.mem_write_valid[ch] = wv;
      if ($urandom_range(0, 1) == 1) bus.mem_read_address[ch*AB +: AB]  = rand_addr();
      if ($urandom_range(0, 1) == 1) bus.mem_write_address[ch*AB +: AB] = rand_addr();
      bus.mem_write_data[ch*DB +: DB] = DB'($urandom);
    end
    @(posedge clk); #1;
    bus.mem_read_valid[ch] = 1'b0; bus.mem_write_valid[ch] = 1'b0;
  endtask

  task automatic rand_ctl(input int n);
    int rst_left;
    rst_left = 0;
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #1;
      if (reset) begin
        if (rst_left == 0) reset = 1'b0; else rst_left--;
      end else if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1; rst_left = $urandom_range(0, 2);
      end
      load_en   = ($urandom_range(0, 5) == 0);
      load_addr = rand_addr();
      load_data = DB'($urandom);
    end
    @(posedge clk); #1;
    reset = 1'b0; load_en = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat0, lat1, rk, wk;
    logic [DB-1:0] rd0, rd1, expv;
    logic ag0, ag1;

    bus.mem_read_valid = '0;  bus.mem_read_address = '0;
    bus.mem_write_valid = '0; bus.mem_write_address = '0; bus.mem_write_data = '0;
    bus2.mem_read_valid = '0;  bus2.mem_read_address = '0;
    bus2.mem_write_valid = '0; bus2.mem_write_address = '0; bus2.mem_write_data = '0;

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset ch_busy", 32'(bus.ch_busy), 32'd0);
    check("reset read_data", 32'(bus.mem_read_data), 32'd0);
    reset = 1'b0;

    // Known contents everywhere so the model and the array agree.
    for (int a = 0; a < DEPTH; a++) begin
      load_en = 1'b1; load_addr = AB'(a); load_data = DB'($urandom);
      @(posedge clk); #1;
    end
    load_en = 1'b0;

    // Backdoor preload then read with lingering valid.
    do_load(1'b0, 8'h10, 16'hBEEF);
    do_op(1'b0, 0, 1'b0, 8'h10, '0, lat0, rd0, ag0);
    check("beef read latency", 32'(lat0), 32'd2);
    check("beef read data", 32'(rd0), 32'hBEEF);
    check("beef no second ready", 32'(ag0), 32'd0);
    check("beef lane idle", 32'(bus.ch_busy), 32'd0);

    // Write then read back.
    do_op(1'b0, 0, 1'b1, 8'h22, 16'h1234, lat0, rd0, ag0);
    check("write latency", 32'(lat0), 32'd3);
    check("write pulse width", 32'(ag0), 32'd0);
    do_op(1'b0, 0, 1'b0, 8'h22, '0, lat0, rd0, ag0);
    check("write readback", 32'(rd0), 32'h1234);

    // Both lanes write the same address on the same edge.
    fork
      do_op(1'b0, 0, 1'b1, 8'h05, 16'hAAAA, lat0, rd0, ag0);
      do_op(1'b0, 1, 1'b1, 8'h05, 16'h5555, lat1, rd1, ag1);
    join
    check("dual write lat ch0", 32'(lat0), 32'd3);
    check("dual write lat ch1", 32'(lat1), 32'd3);
    do_op(1'b0, 0, 1'b0, 8'h05, '0, lat0, rd0, ag0);
    check("dual write winner", 32'(rd0), 32'h5555);

    // Read and write raised together: read first, write after release.
    drive_req(1'b0, 0, 1'b0, 1'b1, 8'h40, '0);
    drive_req(1'b0, 0, 1'b1, 1'b1, 8'h41, 16'h4321);
    rk = -1; wk = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.mem_read_ready[0] && rk < 0)  rk = k;
      if (bus.mem_write_ready[0] && wk < 0) wk = k;
      @(posedge clk); #1;
      if (rk > 0) bus.mem_read_valid[0]  = 1'b0;
      if (wk > 0) bus.mem_write_valid[0] = 1'b0;
    end
    check("priority read slot", 32'(rk), 32'd4);
    check("priority write slot", 32'(wk), 32'd10);
    do_op(1'b0, 0, 1'b0, 8'h41, '0, lat0, rd0, ag0);
    check("priority write data", 32'(rd0), 32'h4321);

    // Reset while a write is in flight.
    do_load(1'b0, 8'h30, 16'h0001);
    drive_req(1'b0, 0, 1'b1, 1'b1, 8'h30, 16'hDEAD);
    @(posedge clk); #1;
    @(negedge clk);
    check("inflight busy", 32'(bus.ch_busy[0]), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.mem_write_valid[0] = 1'b0;
    @(negedge clk);
    check("abort ready", 32'(bus.mem_write_ready[0]), 32'd0);
    check("abort busy", 32'(bus.ch_busy[0]), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    do_op(1'b0, 0, 1'b0, 8'h30, '0, lat0, rd0, ag0);
    check("abort array kept", 32'(rd0), 32'h0001);

    // Consecutive reads 0..3.
    for (int a = 0; a < 4; a++) begin
      expv = m_mem[a];
      do_op(1'b0, 0, 1'b0, AB'(a), '0, lat0, rd0, ag0);
      check($sformatf("seq read %0d", a), 32'(rd0), 32'(expv));
      check($sformatf("seq read lat %0d", a), 32'(lat0), 32'd2);
    end
    check("seq lanes idle", 32'(bus.ch_busy), 32'd0);

    // Write-disabled device: acknowledged, array untouched, load still works.
    do_load(1'b1, 8'h22, 16'h0777);
    do_op(1'b1, 0, 1'b1, 8'h22, 16'h1234, lat0, rd0, ag0);
    check("ro write latency", 32'(lat0), 32'd2);
    check("ro write pulse width", 32'(ag0), 32'd0);
    do_op(1'b1, 0, 1'b0, 8'h22, '0, lat0, rd0, ag0);
    check("ro read latency", 32'(lat0), 32'd2);
    check("ro read unchanged", 32'(rd0), 32'h0777);
    check("ro lane idle", 32'(bus2.ch_busy), 32'd0);

    // Randomized traffic on both lanes with loads and occasional resets.
    fork
      rand_chan(0, 4000);
      rand_chan(1, 4000);
      rand_ctl(4000);
    join
    repeat (12) @(posedge clk);
    #1;
    check("final lanes idle", 32'(bus.ch_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Cycle-accurate external memory model answering the controller's per-channel read/write valid/ready protocol. It is the responder at the far end of the memory controller.
- Holds a 2^ADDR_BITS x DATA_BITS array and serves each channel independently, with programmable read and write latency.
- Includes a backdoor load port so benches can preload program or data memory.
- Used in simulation tops as data memory (WRITE_ENABLE=1) or program memory (WRITE_ENABLE=0).

Parameters:
- ADDR_BITS, 8, word address width; array depth 2^ADDR_BITS.
- DATA_BITS, 16, word width.
- NUM_CHANNELS, 1, independent request channels.
- READ_LATENCY, 2, edges from read request acceptance to read_ready high; must be >=1.
- WRITE_LATENCY, 2, edges from write request acceptance to write_ready high; must be >=1.
- WRITE_ENABLE, 1, 0 = writes are acknowledged but never modify the array.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mem_read_valid  in  NUM_CHANNELS  per-channel read request.
- mem_read_address  in  NUM_CHANNELS*ADDR_BITS  channel i at [i*ADDR_BITS +: ADDR_BITS].
- mem_read_ready  out  NUM_CHANNELS  one-cycle read completion pulse.
- mem_read_data  out  NUM_CHANNELS*DATA_BITS  read data, channel i at [i*DATA_BITS +: DATA_BITS].
- mem_write_valid  in  NUM_CHANNELS  per-channel write request.
- mem_write_address  in  NUM_CHANNELS*ADDR_BITS  write address.
- mem_write_data  in  NUM_CHANNELS*DATA_BITS  write data.
- mem_write_ready  out  NUM_CHANNELS  one-cycle write completion pulse.
- load_en  in  1  backdoor write strobe.
- load_addr  in  ADDR_BITS  backdoor address.
- load_data  in  DATA_BITS  backdoor data.
- ch_busy  out  NUM_CHANNELS  channel not in IDLE.

Behaviour:
- Reset (async, while reset=1):
  - every channel goes to IDLE;
  - mem_read_ready=0, mem_write_ready=0, mem_read_data=0, ch_busy=0;
  - latency counters cleared;
  - array contents are preserved;
  - load port is ignored.
  Reset asserted mid-request abandons the request with no array update.
- Per-channel FSM, states IDLE, BUSY, RESPOND, RELEASE:
  - IDLE:
    - mem_read_valid[i]=1 at an edge → latch address, kind=READ, cnt=READ_LATENCY-1, go to BUSY.
    - Else mem_write_valid[i]=1 → latch address and data, kind=WRITE, cnt=WRITE_LATENCY-1, go to BUSY.
    - Read has priority when both are high; the write stays pending.
  - BUSY:
    - cnt==0 at an edge → go to RESPOND. At that same edge, assert the matching ready and either register mem_read_data from the array or commit the write (if WRITE_ENABLE=1).
    - Otherwise cnt decrements.
    - Result: ready rises exactly LATENCY edges after the accepting edge.
  - RESPOND: ready is high for exactly one cycle; next edge → RELEASE, ready=0.
  - RELEASE: wait until the request's valid is sampled low, then go to IDLE. This keeps the still-high valid seen in the cycle after ready from being re-accepted.
- Minimum turnaround per channel: accept + LATENCY + 2 edges.
- Valid dropped while BUSY (protocol violation): the request still completes, ready still pulses, and RELEASE exits on the first edge.
- mem_read_data[i] holds its value until the next read completion on channel i. It is unaffected by writes.
- Array write ordering within one edge (later overrides earlier):
  1. load port;
  2. channel writes in ascending channel index (highest index wins on the same address).
- Read and write completing to the same address on the same edge: the read returns the pre-edge value.
- WRITE_ENABLE=0: write requests follow the full FSM and pulse write_ready; the array is unchanged. The load port still works.
- ch_busy[i] = (state != IDLE).
- Address indexing is unsigned and full-width, with no wrap logic needed.

Test Plan:
- Preload addr 0x10=0xBEEF via load port; ch0 read 0x10 with READ_LATENCY=2, valid held until ready → read_ready high exactly 1 cycle, 2 edges after acceptance, data 0xBEEF; no second response while valid lingers one cycle.
- ch0 write 0x22=0x1234 → write_ready one-cycle pulse after 2 edges; then read 0x22 → 0x1234. Repeat with WRITE_ENABLE=0 → ready still pulses, read returns the preloaded value.
- NUM_CHANNELS=2, both channels write 0x05 on the same edge (0xAAAA ch0, 0x5555 ch1) → array 0x05=0x5555; both readies pulse on the same cycle.
- read_valid and write_valid both high in IDLE → read serviced first; write accepted only after RELEASE→IDLE.
- Assert reset while ch0 is BUSY on a write to 0x30 (previously 0x0001) → ready stays 0, ch_busy=0, 0x30 still reads 0x0001 after reset.
- Back-to-back reads at 0x00..0x03 driven by the real memory controller → four correct responses, ch_busy returns to 0, no hang.
